// File: rtl/pet_stats_engine_pkg.sv
// Shared types and saturating arithmetic for the pet stats engine.
package pet_pkg;

  typedef enum logic [1:0] {
    ALIVE = 2'b00,
    SLEEP = 2'b01,
    SICK  = 2'b10,
    DEAD  = 2'b11
  } pet_state_e;

  localparam int HEALTH_IDX = 0;
  localparam int ENERGY_IDX = 1;

  // Add clamped to the largest value representable in w bits.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] max;
    sum = {1'b0, a} + {1'b0, b};
    max = (33'd1 << w) - 33'd1;
    return (sum > max) ? max[31:0] : sum[31:0];
  endfunction

  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/pet_stats_engine_if.sv
// Care-action handshake between a requester and the pet stats engine.
interface pet_stats_engine_if #(parameter int IDX_W = 3);
  logic             action_valid;
  logic [IDX_W-1:0] action_id;
  logic             action_ready;
  logic             action_err;

  modport master (output action_valid, action_id, input action_ready, action_err);
  modport slave  (input action_valid, action_id, output action_ready, action_err);
endinterface

// File: rtl/pet_stats_engine_tick_gen.sv
// Game-tick prescaler: counts while ena is high, one-cycle tick after TICK_DIV-1.
module pet_tick_gen #(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (ena) begin
        if (r_cnt == CW'(TICK_DIV - 1)) begin
          r_cnt  <= '0;
          r_tick <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign tick = r_tick;
endmodule

// File: rtl/pet_stats_engine.sv
// Pet stats engine: saturating stat counters, tick decay, care actions, life-cycle FSM.
module pet_stats_engine
  import pet_pkg::*;
#(
  parameter int NUM_STATS    = 6,
  parameter int STAT_W       = 4,
  parameter int TICK_DIV     = 10_000_000,
  parameter int INIT_VAL     = 8,
  parameter int DECAY_STEP   = 1,
  parameter int ACTION_STEP  = 4,
  parameter int THRESH_LOW   = 3,
  parameter int SICK_COUNT   = 2,
  parameter int COOLDOWN_CYC = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic [3:0]                    rand_in,
  pet_stats_engine_if.slave             act,
  input  logic                          revive,
  output logic [NUM_STATS*STAT_W-1:0]   stats_flat,
  output logic [NUM_STATS-1:0]          low_mask,
  output logic [1:0]                    pet_state,
  output logic                          tick
);
  localparam int                CD_W     = $clog2(COOLDOWN_CYC + 2);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [NUM_STATS-1:0][STAT_W-1:0] r_stats, w_stats_nxt;
  pet_state_e                       r_state, w_state_nxt;
  logic [CD_W-1:0]                  r_cd;
  logic                             r_err;
  logic                             w_tick, w_live, w_accept;
  logic [31:0]                      w_zero_cnt;

  pet_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .tick  (w_tick)
  );

  assign w_live           = (r_state == ALIVE) || (r_state == SICK);
  assign act.action_ready = w_live && (r_cd == '0);
  assign w_accept         = act.action_valid && act.action_ready;

  // Decay is applied before the action boost so a same-cycle collision lands both.
  for (genvar i = 0; i < NUM_STATS; i++) begin : g_stat
    logic [31:0] w_dec, w_inc;
    always_comb begin
      w_dec = 32'd0;
      w_inc = 32'd0;
      if (w_tick && w_live) begin
        w_dec = 32'(DECAY_STEP);
        if (32'(rand_in) == i) w_dec = w_dec + 32'd1;
        if ((r_state == SICK) && (i == HEALTH_IDX)) w_dec = w_dec + 32'd1;
      end
      if (w_tick && (r_state == SLEEP) && (i == ENERGY_IDX)) w_inc = 32'd1;
      if (w_accept && (32'(act.action_id) == i)) w_inc = w_inc + 32'(ACTION_STEP);
    end
    assign w_stats_nxt[i] = STAT_W'(sat_add(sat_sub(32'(r_stats[i]), w_dec), w_inc, STAT_W));
    assign low_mask[i]    = 32'(r_stats[i]) <= 32'(THRESH_LOW);
  end

  always_comb begin
    w_zero_cnt = 32'd0;
    for (int i = 0; i < NUM_STATS; i++)
      if (r_stats[i] == '0) w_zero_cnt = w_zero_cnt + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_stats <= {NUM_STATS{STAT_W'(INIT_VAL)}};
    else if ((r_state == DEAD) && revive)
      r_stats <= {NUM_STATS{STAT_W'(INIT_VAL)}};
    else
      r_stats <= w_stats_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cd  <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept && (32'(act.action_id) >= 32'(NUM_STATS));
      if (w_accept)        r_cd <= CD_W'(COOLDOWN_CYC);
      else if (r_cd != '0) r_cd <= r_cd - CD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ALIVE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if ((r_state != DEAD) && (r_stats[HEALTH_IDX] == '0)) begin
      w_state_nxt = DEAD;
    end else begin
      case (r_state)
        ALIVE: if (r_stats[ENERGY_IDX] == '0)                w_state_nxt = SLEEP;
               else if (w_zero_cnt >= 32'(SICK_COUNT))       w_state_nxt = SICK;
        SLEEP: if (r_stats[ENERGY_IDX] == STAT_MAX)          w_state_nxt = ALIVE;
        SICK:  if ((w_zero_cnt < 32'(SICK_COUNT)) &&
                   (32'(r_stats[HEALTH_IDX]) > 32'(THRESH_LOW))) w_state_nxt = ALIVE;
        DEAD:  if (revive)                                   w_state_nxt = ALIVE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  assign stats_flat     = r_stats;
  assign pet_state      = r_state;
  assign tick           = w_tick;
  assign act.action_err = r_err;
endmodule

// File: tb/tb_pet_stats_engine.sv
// Directed bench for pet_stats_engine with TICK_DIV=4; expected values hand-computed.
module tb_pet_stats_engine;
  import pet_pkg::*;

  localparam int NS = 6;
  localparam int SW = 4;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             ena     = 1'b0;
  logic             revive  = 1'b0;
  logic [3:0]       rand_in = 4'hF;
  logic [NS*SW-1:0] stats_flat;
  logic [NS-1:0]    low_mask;
  logic [1:0]       pet_state;
  logic             tick;
  int               checks   = 0;
  int               failures = 0;

  pet_stats_engine_if #(.IDX_W(3)) act_if ();

  always #5 clk = ~clk;

  pet_stats_engine #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .rand_in    (rand_in),
    .act        (act_if),
    .revive     (revive),
    .stats_flat (stats_flat),
    .low_mask   (low_mask),
    .pet_state  (pet_state),
    .tick       (tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    int n = 0;
    while (tick !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    chk("tick_seen", 32'(tick), 32'd1);
  endtask

  task automatic tick_apply();
    wait_tick();
    cyc();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic act_go(input logic [2:0] id);
    act_if.action_valid = 1'b1;
    act_if.action_id    = id;
    cyc();
    act_if.action_valid = 1'b0;
  endtask

  task automatic drain_to_sick();
    rand_in = 4'd2;
    repeat (4) tick_apply();
    rand_in = 4'd3;
    repeat (2) tick_apply();
    rand_in = 4'hF;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    act_if.action_valid = 1'b0;
    act_if.action_id    = 3'd0;
    cyc();
    cyc();
    chk("rst_stats", 32'(stats_flat), 32'h888888);
    chk("rst_state", 32'(pet_state), 32'(ALIVE));
    chk("rst_low",   32'(low_mask), 32'h0);
    chk("rst_tick",  32'(tick), 32'd0);
    chk("rst_err",   32'(act_if.action_err), 32'd0);
    chk("rst_ready", 32'(act_if.action_ready), 32'd1);

    // Decay: first tick on the 4th cycle after reset release
    rst_n = 1'b1;
    ena   = 1'b1;
    cyc();      chk("tick_c1", 32'(tick), 32'd0);
    cyc(); cyc(); chk("tick_c3", 32'(tick), 32'd0);
    cyc();      chk("tick_c4", 32'(tick), 32'd1);
    cyc();      chk("decay1", 32'(stats_flat), 32'h777777);
    repeat (2) tick_apply();
    chk("decay3", 32'(stats_flat), 32'h555555);
    chk("low3",   32'(low_mask), 32'h00);
    repeat (2) tick_apply();
    chk("decay5", 32'(stats_flat), 32'h333333);
    chk("low5",   32'(low_mask), 32'h3F);

    // Handshake and cooldown with the prescaler frozen
    do_reset();
    chk("reset_b", 32'(stats_flat), 32'h888888);
    repeat (3) tick_apply();
    chk("pre_act", 32'(stats_flat), 32'h555555);
    ena = 1'b0;
    act_go(3'd2);
    chk("act2",    32'(stats_flat), 32'h555955);
    chk("cd_rdy1", 32'(act_if.action_ready), 32'd0);
    cyc(); chk("cd_rdy2", 32'(act_if.action_ready), 32'd0);
    cyc(); chk("cd_rdy3", 32'(act_if.action_ready), 32'd0);
    cyc(); chk("cd_rdy4", 32'(act_if.action_ready), 32'd1);
    act_go(3'd7);
    chk("err_pulse", 32'(act_if.action_err), 32'd1);
    chk("err_stats", 32'(stats_flat), 32'h555955);
    cyc(); chk("err_clear", 32'(act_if.action_err), 32'd0);
    cyc(); cyc();
    chk("err_rdy", 32'(act_if.action_ready), 32'd1);

    // Saturation: 6 -> 10 -> 14 -> 15
    do_reset();
    ena = 1'b1;
    repeat (2) tick_apply();
    chk("pre_sat", 32'(stats_flat), 32'h666666);
    ena = 1'b0;
    act_go(3'd2); chk("sat_a10", 32'(stats_flat), 32'h666A66);
    repeat (3) cyc();
    act_go(3'd2); chk("sat_a14", 32'(stats_flat), 32'h666E66);
    repeat (3) cyc();
    act_go(3'd2); chk("sat_a15", 32'(stats_flat), 32'h666F66);
    repeat (3) cyc();
    chk("sat_rdy", 32'(act_if.action_ready), 32'd1);

    // Random decay and same-cycle tick/accept collision
    ena     = 1'b1;
    rand_in = 4'd3;
    wait_tick();
    act_if.action_valid = 1'b1;
    act_if.action_id    = 3'd3;
    cyc();
    act_if.action_valid = 1'b0;
    chk("collide", 32'(stats_flat), 32'h558E55);
    tick_apply();
    chk("rand3",   32'(stats_flat), 32'h446D44);
    rand_in = 4'd9;
    tick_apply();
    chk("rand_oob", 32'(stats_flat), 32'h335C33);
    rand_in = 4'd5;
    tick_apply();
    chk("rand5",     32'(stats_flat), 32'h124B22);
    chk("rand5_low", 32'(low_mask), 32'h33);
    chk("rand5_st",  32'(pet_state), 32'(ALIVE));

    // SLEEP: drain energy, then climb back to max
    do_reset();
    rand_in = 4'd1;
    repeat (4) tick_apply();
    chk("e_zero",   32'(stats_flat), 32'h444404);
    chk("e_lag",    32'(pet_state), 32'(ALIVE));
    cyc();
    chk("sleep_st",  32'(pet_state), 32'(SLEEP));
    chk("sleep_rdy", 32'(act_if.action_ready), 32'd0);
    act_go(3'd0);
    chk("sleep_noacc", 32'(stats_flat), 32'h444404);
    for (int k = 1; k <= 15; k++) begin
      logic [23:0] e;
      tick_apply();
      e = 24'h444404 | (24'(k) << 4);
      chk("sleep_climb", 32'(stats_flat), 32'(e));
    end
    chk("sleep_hold", 32'(pet_state), 32'(SLEEP));
    cyc();
    chk("wake_st",  32'(pet_state), 32'(ALIVE));
    chk("wake_rdy", 32'(act_if.action_ready), 32'd1);

    // SICK -> DEAD -> revive
    rand_in = 4'hF;
    do_reset();
    drain_to_sick();
    chk("sick_stats", 32'(stats_flat), 32'h220022);
    cyc();
    chk("sick_st",  32'(pet_state), 32'(SICK));
    chk("sick_rdy", 32'(act_if.action_ready), 32'd1);
    revive = 1'b1;
    cyc();
    revive = 1'b0;
    chk("rev_ign_stats", 32'(stats_flat), 32'h220022);
    chk("rev_ign_st",    32'(pet_state), 32'(SICK));
    act_go(3'd0);
    chk("sick_act", 32'(stats_flat), 32'h220026);
    tick_apply();
    chk("sick_t1", 32'(stats_flat), 32'h110014);
    chk("sick_t1st", 32'(pet_state), 32'(SICK));
    tick_apply();
    chk("sick_t2", 32'(stats_flat), 32'h000002);
    tick_apply();
    chk("sick_t3", 32'(stats_flat), 32'h000000);
    cyc();
    chk("dead_st",  32'(pet_state), 32'(DEAD));
    chk("dead_rdy", 32'(act_if.action_ready), 32'd0);
    tick_apply();
    chk("dead_frozen", 32'(stats_flat), 32'h000000);
    chk("dead_hold",   32'(pet_state), 32'(DEAD));
    revive = 1'b1;
    cyc();
    revive = 1'b0;
    chk("revive_stats", 32'(stats_flat), 32'h888888);
    chk("revive_st",    32'(pet_state), 32'(ALIVE));
    chk("revive_rdy",   32'(act_if.action_ready), 32'd1);

    // Mid-operation reset during SICK with cooldown running
    drain_to_sick();
    cyc();
    chk("g_sick", 32'(pet_state), 32'(SICK));
    act_go(3'd4);
    chk("g_cd", 32'(act_if.action_ready), 32'd0);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("mrst_stats", 32'(stats_flat), 32'h888888);
    chk("mrst_st",    32'(pet_state), 32'(ALIVE));
    chk("mrst_rdy",   32'(act_if.action_ready), 32'd1);
    chk("mrst_tick",  32'(tick), 32'd0);
    chk("mrst_err",   32'(act_if.action_err), 32'd0);
    cyc();        chk("mrst_c1", 32'(tick), 32'd0);
    cyc(); cyc(); chk("mrst_c3", 32'(tick), 32'd0);
    cyc();        chk("mrst_c4", 32'(tick), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
